// File: rtl/aud_dsp_speed.sv
// aud_dsp_speed: playback-speed DSP stage feeding the I2S DAC serializer.
// Fetches one SRAM sample per LRCK frame; modes: normal, fast (skip),
// slow hold, slow linear interpolation.
// Macro AUD_DSP_LINEAR_EN: when defined, slow_1 interpolates linearly;
// when undefined, slow_1 behaves as slow_0 and no interpolation logic exists.
module aud_dsp_speed #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int MAX_SPEED = 8
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic              o_done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;
    typedef enum logic [1:0] {M_NORM, M_FAST, M_HOLD, M_LIN} mode_t;

    localparam logic [3:0] MAX_N = 4'(MAX_SPEED);

    state_t            state, state_nx;
    mode_t             mode_q, req_mode, eff_mode;
    logic [3:0]        n_q, n_req, eff_n, k, k_inc, k_next;
    logic              lrck_d, tick, play_tick, fetch, end_hit;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W:0]   addr_sum;
    logic              dac_upd;
    logic [DATA_W-1:0] dac_nx;

    // Frame strobe on the rising LRCK edge
    assign tick      = i_daclrck & ~lrck_d;
    assign play_tick = tick && (state == S_PLAY);

    // Speed conditioning (0 -> 1, clamp to MAX_SPEED) and mode priority
    always_comb begin
        if (i_speed == 4'd0)
            n_req = 4'd1;
        else if (i_speed > MAX_N)
            n_req = MAX_N;
        else
            n_req = i_speed;

        if (i_fast)
            req_mode = M_FAST;
`ifdef AUD_DSP_LINEAR_EN
        else if (i_slow_1)
            req_mode = M_LIN;
        else if (i_slow_0)
            req_mode = M_HOLD;
`else
        else if (i_slow_1 || i_slow_0)
            req_mode = M_HOLD;
`endif
        else
            req_mode = M_NORM;
    end

    // Effective mode/step: fresh request at k == 0, latched values mid-frame-group
    always_comb begin
        eff_mode = (k == 4'd0) ? req_mode : mode_q;
        eff_n    = (k == 4'd0) ? n_req    : n_q;
        step     = (eff_mode == M_FAST) ? ADDR_W'(eff_n) : ADDR_W'(1);
        addr_sum = {1'b0, o_sram_addr} + {1'b0, step};
        fetch    = (k == 4'd0);
        // step >= 1, so addr == end is covered by addr + step > end
        end_hit  = fetch && (addr_sum > {1'b0, i_end_addr});
        k_inc    = k + 4'd1;
        if ((eff_mode == M_HOLD || eff_mode == M_LIN) && (k_inc != eff_n))
            k_next = k_inc;
        else
            k_next = '0;
    end

`ifdef AUD_DSP_LINEAR_EN
    logic signed [DATA_W-1:0] prev, cur;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+5:0] prod, quot;
    logic        [DATA_W-1:0] interp;

    // Interpolated sample prev + (cur - prev) * k / n, truncating toward zero
    always_comb begin
        diff   = {cur[DATA_W-1], cur} - {prev[DATA_W-1], prev};
        prod   = $signed({{5{diff[DATA_W]}}, diff}) * $signed({{(DATA_W+2){1'b0}}, k});
        quot   = prod / $signed({{(DATA_W+2){1'b0}}, eff_n});
        interp = prev + DATA_W'(quot);
    end

    // Sample pair for interpolation, shifted on each non-final fetch
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev <= '0;
            cur  <= '0;
        end else if (i_stop) begin
            prev <= '0;
            cur  <= '0;
        end else if (play_tick && fetch && !end_hit) begin
            prev <= cur;
            cur  <= i_sram_data;
        end
    end
`endif

    // Selects the next DAC sample and whether it changes this tick
    always_comb begin
        dac_upd = 1'b0;
        dac_nx  = i_sram_data;
        if (fetch) begin
            dac_upd = 1'b1;
`ifdef AUD_DSP_LINEAR_EN
            if (!end_hit && eff_mode == M_LIN)
                dac_nx = cur;
`endif
        end
`ifdef AUD_DSP_LINEAR_EN
        else if (eff_mode == M_LIN) begin
            dac_upd = 1'b1;
            dac_nx  = interp;
        end
`endif
    end

    // Datapath: address, frame counter, latched mode, DAC sample, done pulse
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_d      <= 1'b0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
            o_done      <= 1'b0;
            k           <= '0;
            mode_q      <= M_NORM;
            n_q         <= 4'd1;
        end else begin
            lrck_d <= i_daclrck;
            o_done <= 1'b0;
            if (i_stop) begin
                o_sram_addr <= '0;
                o_dac_data  <= '0;
                k           <= '0;
            end else if (play_tick) begin
                if (k == 4'd0) begin
                    mode_q <= req_mode;
                    n_q    <= n_req;
                end
                k <= end_hit ? '0 : k_next;
                if (dac_upd)
                    o_dac_data <= dac_nx;
                if (fetch) begin
                    if (end_hit) begin
                        o_sram_addr <= '0;
                        o_done      <= 1'b1;
                    end else begin
                        o_sram_addr <= addr_sum[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    // State register
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state: stop > end-of-recording/pause > start
    always_comb begin
        state_nx = state;
        if (i_stop) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_start) state_nx = S_PLAY;
                S_PLAY: begin
                    if (play_tick && end_hit)
                        state_nx = S_IDLE;
                    else if (i_pause)
                        state_nx = S_PAUSE;
                end
                S_PAUSE: if (i_start) state_nx = S_PLAY;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Serializer enable only while playing
    always_comb begin
        o_player_en = (state == S_PLAY);
    end

endmodule

// File: tb/tb_aud_dsp_speed.sv
// Self-checking bench for aud_dsp_speed: table of per-tick vectors plus
// hand-written pause and stop sequences, checked through an expectation queue.
module tb_aud_dsp_speed;

    localparam int AW = 20;
    localparam int DW = 16;

    logic                 clk, rst_n, lrck, start, pause, stop;
    logic                 fast, slow0, slow1;
    logic [3:0]           speed;
    logic [AW-1:0]        end_addr, sram_addr;
    logic signed [DW-1:0] sram_data, dac;
    logic                 en, done;

    logic signed [DW-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    aud_dsp_speed #(.ADDR_W(AW), .DATA_W(DW), .MAX_SPEED(8)) dut (
        .i_bclk(clk), .i_rst_n(rst_n), .i_daclrck(lrck),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_fast(fast), .i_slow_0(slow0), .i_slow_1(slow1),
        .i_speed(speed), .i_end_addr(end_addr), .i_sram_data(sram_data),
        .o_sram_addr(sram_addr), .o_dac_data(dac),
        .o_player_en(en), .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: combinational read at the DUT address
    always_comb sram_data = mem[sram_addr[3:0]];

    typedef struct {
        int                   scen;   // >= 0: load memory set and restart
        logic                 fast, s0, s1;
        logic [3:0]           speed;
        logic [AW-1:0]        end_a;
        logic signed [DW-1:0] dac;
        logic [AW-1:0]        addr;
        logic                 done, en;
    } vec_t;

    typedef struct {
        string                name;
        logic signed [DW-1:0] dac;
        logic [AW-1:0]        addr;
        logic                 done, en;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input int sc, input logic f, input logic s0, input logic s1,
                       input logic [3:0] sp, input int ea, input int d, input int a,
                       input logic dn, input logic e);
        vec_t v;
        v.scen = sc; v.fast = f; v.s0 = s0; v.s1 = s1; v.speed = sp;
        v.end_a = AW'(ea); v.dac = DW'(d); v.addr = AW'(a); v.done = dn; v.en = e;
        tbl.push_back(v);
    endtask

    task automatic push_exp(input string nm, input int d, input int a, input logic dn, input logic e);
        exp_t x;
        x.name = nm; x.dac = DW'(d); x.addr = AW'(a); x.done = dn; x.en = e;
        sb.push_back(x);
    endtask

    task automatic check_pop();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            checks--;
            x = sb.pop_front();
            chk({x.name, ".dac"},  dac,  x.dac);
            chk({x.name, ".addr"}, sram_addr, x.addr);
            chk({x.name, ".done"}, done, x.done);
            chk({x.name, ".en"},   en,   x.en);
        end
    endtask

    task automatic load_mem(input int id);
        for (int i = 0; i < 16; i++) begin
            case (id)
                0: mem[i] = DW'(100 * (i + 1));
                1: mem[i] = DW'(i);
                2: mem[i] = (i == 0) ? DW'(1000) : DW'(2000);
                3: mem[i] = (i == 0) ? DW'(0) : (i == 1) ? DW'(100) : (i == 2) ? -DW'(100) : DW'(7);
                4: mem[i] = DW'(11 * i);
                default: mem[i] = DW'(40 * (i + 1));
            endcase
        end
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_pause();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
    endtask

    // One LRCK rising edge; returns at the negedge after it was processed
    task automatic do_tick();
        @(negedge clk) lrck = 1'b1;
        @(negedge clk) lrck = 1'b0;
    endtask

    task automatic set_mode(input logic f, input logic s0, input logic s1,
                            input logic [3:0] sp, input logic [AW-1:0] ea);
        @(negedge clk);
        fast = f; slow0 = s0; slow1 = s1; speed = sp; end_addr = ea;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lrck = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        fast = 1'b0; slow0 = 1'b0; slow1 = 1'b0; speed = 4'd1; end_addr = '0;
        load_mem(0);

        // Normal: 100..400, end 3
        add(0, 0, 0, 0, 1, 3, 100, 1, 0, 1);
        add(-1, 0, 0, 0, 1, 3, 200, 2, 0, 1);
        add(-1, 0, 0, 0, 1, 3, 300, 3, 0, 1);
        add(-1, 0, 0, 0, 1, 3, 400, 0, 1, 0);
        // Fast n=3, end 10: next step 12 exceeds end after sample 9
        add(1, 1, 0, 0, 3, 10, 0, 3, 0, 1);
        add(-1, 1, 0, 0, 3, 10, 3, 6, 0, 1);
        add(-1, 1, 0, 0, 3, 10, 6, 9, 0, 1);
        add(-1, 1, 0, 0, 3, 10, 9, 0, 1, 0);
        // Fast speed 12 clamps to 8
        add(1, 1, 0, 0, 12, 10, 0, 8, 0, 1);
        add(-1, 1, 0, 0, 12, 10, 8, 0, 1, 0);
        // Slow hold n=4, end 1; output holds after done
        for (int i = 0; i < 4; i++)
            add(i == 0 ? 2 : -1, 0, 1, 0, 4, 1, 1000, 1, 0, 1);
        add(-1, 0, 1, 0, 4, 1, 2000, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            add(-1, 0, 1, 0, 4, 1, 2000, 0, 0, 0);
        // Slow_1 n=4 over 0, 100, -100, 7
`ifdef AUD_DSP_LINEAR_EN
        for (int i = 0; i < 4; i++) add(i == 0 ? 3 : -1, 0, 0, 1, 4, 3, 0, 1, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 0,   2, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 25,  2, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 50,  2, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 75,  2, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 100, 3, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 50,  3, 0, 1);
        add(-1, 0, 0, 1, 4, 3, 0,   3, 0, 1);
        add(-1, 0, 0, 1, 4, 3, -50, 3, 0, 1);
`else
        for (int i = 0; i < 4; i++) add(i == 0 ? 3 : -1, 0, 0, 1, 4, 3, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(-1, 0, 0, 1, 4, 3, 100, 2, 0, 1);
        for (int i = 0; i < 4; i++) add(-1, 0, 0, 1, 4, 3, -100, 3, 0, 1);
`endif
        add(-1, 0, 0, 1, 4, 3, 7, 0, 1, 0);

        // Reset state, during and after reset
        repeat (3) @(negedge clk);
        chk("rst.dac", dac, 0);
        chk("rst.addr", sram_addr, 0);
        chk("rst.en", en, 0);
        chk("rst.done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.en", en, 0);
        chk("post_rst.dac", dac, 0);

        // Table-driven per-tick vectors
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            set_mode(v.fast, v.s0, v.s1, v.speed, v.end_a);
            if (v.scen >= 0) begin
                load_mem(v.scen);
                pulse_stop();
                pulse_start();
            end
            push_exp($sformatf("vec%0d", i), v.dac, v.addr, v.done, v.en);
            do_tick();
            check_pop();
        end

        // Pause: two ticks, pause held over five ticks, resume at next sample
        set_mode(0, 0, 0, 1, 15);
        load_mem(4);
        pulse_stop();
        pulse_start();
        push_exp("pause.t1", 0, 1, 0, 1);  do_tick(); check_pop();
        push_exp("pause.t2", 11, 2, 0, 1); do_tick(); check_pop();
        pulse_pause();
        chk("pause.en_low", en, 0);
        for (int i = 0; i < 5; i++) begin
            push_exp($sformatf("pause.frozen%0d", i), 11, 2, 0, 0);
            do_tick();
            check_pop();
        end
        pulse_start();
        chk("pause.en_resume", en, 1);
        push_exp("pause.resume", 22, 3, 0, 1); do_tick(); check_pop();

        // Stop coincident with a tick at k == 2, then speed 0 plays at speed 1
        set_mode(0, 0, 1, 4, 15);
        load_mem(5);
        pulse_stop();
        pulse_start();
`ifdef AUD_DSP_LINEAR_EN
        push_exp("stop.t1", 0, 1, 0, 1);  do_tick(); check_pop();
        push_exp("stop.t2", 10, 1, 0, 1); do_tick(); check_pop();
`else
        push_exp("stop.t1", 40, 1, 0, 1); do_tick(); check_pop();
        push_exp("stop.t2", 40, 1, 0, 1); do_tick(); check_pop();
`endif
        @(negedge clk); stop = 1'b1; lrck = 1'b1;
        @(negedge clk); stop = 1'b0; lrck = 1'b0;
        chk("stop.dac", dac, 0);
        chk("stop.addr", sram_addr, 0);
        chk("stop.en", en, 0);
        chk("stop.done", done, 0);
        set_mode(0, 0, 1, 0, 15);
        pulse_start();
`ifdef AUD_DSP_LINEAR_EN
        push_exp("spd0.t1", 0, 1, 0, 1);
        push_exp("spd0.t2", 40, 2, 0, 1);
        push_exp("spd0.t3", 80, 3, 0, 1);
`else
        push_exp("spd0.t1", 40, 1, 0, 1);
        push_exp("spd0.t2", 80, 2, 0, 1);
        push_exp("spd0.t3", 120, 3, 0, 1);
`endif
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check_pop();
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aud_dsp_speed.md
Name: aud_dsp_speed

Overview:
- Playback-speed DSP stage directly upstream of the I2S DAC serializer.
- Fetches 16-bit samples from SRAM once per LRCK frame and applies the selected mode: normal, fast (skip), slow with sample hold, or slow with linear interpolation.
- Drives the serializer's sample data and enable inputs.
- Runs on the audio bit clock.

Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width (signed two's complement)
- MAX_SPEED, 8, largest speed factor; larger requests clamp to this

Ports:
- i_bclk  in  1  audio bit clock, sole clock
- i_rst_n  in  1  asynchronous active-low reset
- i_daclrck  in  1  DAC LR clock, synchronous to i_bclk
- i_start  in  1  one-cycle pulse: start/resume playback
- i_pause  in  1  one-cycle pulse: pause
- i_stop  in  1  one-cycle pulse: stop, rewind to address 0
- i_fast  in  1  fast mode select
- i_slow_0  in  1  slow mode, sample hold
- i_slow_1  in  1  slow mode, linear interpolation
- i_speed  in  4  speed factor n
- i_end_addr  in  ADDR_W  last valid recorded address
- i_sram_data  in  DATA_W  SRAM read data at o_sram_addr
- o_sram_addr  out  ADDR_W  SRAM read address
- o_dac_data  out  DATA_W  sample to serializer
- o_player_en  out  1  serializer enable
- o_done  out  1  one-cycle pulse at end of recording

Behaviour:
- Reset: all outputs 0; state IDLE; internal prev/cur samples 0; frame counter k = 0.
- Frame tick: one-cycle strobe on the i_daclrck 0->1 edge, detected by a one-register delay. All datapath updates occur only on ticks.
- i_speed conditioning: 0 is treated as 1; values above MAX_SPEED clamp to MAX_SPEED.
- Mode priority: fast > slow_1 > slow_0 > normal.
- Mode and n are latched only on ticks where k == 0, so a change never lands mid-interpolation.
- States:
  - IDLE -> PLAY on i_start. Address is unchanged, 0 after reset or stop.
  - PLAY -> PAUSE on i_pause.
  - PAUSE -> PLAY on i_start.
  - Any state -> IDLE on i_stop: address 0, k 0, o_dac_data 0.
- Command priority: i_stop > i_pause > i_start.
- o_player_en = 1 only in PLAY. Entering PAUSE or IDLE deasserts it on the next cycle.
- In PAUSE, address, k, prev, cur and o_dac_data are frozen.
- Data timing: i_sram_data is valid for the current o_sram_addr at every tick. At a fetching tick, that data is consumed, then the address advances.
- Normal (n ignored): o_dac_data <= i_sram_data; addr += 1.
- Fast: o_dac_data <= i_sram_data; addr += n.
- Slow hold, on each tick:
  - If k == 0: o_dac_data <= i_sram_data; addr += 1.
  - Otherwise o_dac_data holds.
  - k <= (k + 1) mod n.
- Slow linear, on each tick:
  - If k == 0: prev <= cur; cur <= i_sram_data; addr += 1; o_dac_data <= old cur.
  - Otherwise o_dac_data <= prev + ((cur - prev) * k) / n.
  - Difference is computed in DATA_W+1 bits signed; the division truncates toward zero; the result always lies between prev and cur inclusive.
  - k <= (k + 1) mod n.
- End of recording: when a fetching tick consumes the data at addr == i_end_addr, or addr + step would exceed i_end_addr:
  - that sample is output;
  - o_done pulses one cycle;
  - state goes to IDLE and addr resets to 0;
  - o_dac_data holds its last value.
- Address arithmetic never wraps past i_end_addr.
- Simultaneous events:
  - A tick in the same cycle as i_pause: the tick is processed, then PAUSE is entered.
  - A tick in the same cycle as i_stop: i_stop wins and the tick is discarded.
- Reset asserted mid-playback returns everything to reset values immediately.

Optional Feature:
- Macro: AUD_DSP_LINEAR_EN.
- Defined: slow_1 performs linear interpolation as specified above.
- Undefined: slow_1 behaves exactly as slow_0 (hold), and the interpolation datapath (prev register, multiply, divide) is not synthesized.

Test Plan:
- Normal play, SRAM[0..3] = 100, 200, 300, 400, i_end_addr = 3: o_dac_data = 100, 200, 300, 400 on successive ticks; o_done pulses after 400; state IDLE; addr 0.
- Fast n = 3, SRAM[a] = a, i_end_addr = 10: outputs 0, 3, 6, 9; then o_done, because the next step (12) exceeds 10.
- Slow hold n = 4, SRAM = 1000, 2000: 1000 for 4 ticks, then 2000 for 4 ticks; addr increments every 4th tick.
- Slow linear n = 4, SRAM = 0, 100, -100: after priming, outputs 0, 25, 50, 75, 100, 50, 0, -50 (truncation toward zero verified on negative slope); with macro undefined, outputs are held values only.
- Pause after 2 ticks, hold pause for 5 ticks, then start: o_player_en low, address and output frozen during pause; playback resumes at the next sample.
- i_stop coincident with a tick mid-slow-linear (k = 2), then i_speed = 0: addr 0, o_dac_data 0, k 0; the next i_start plays at speed 1.
